transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/uart_tx_pkg.sv | 39 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/transmitter.sv | 161 ++++++++++++++++
 tb/tb_transmitter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter (uart_baud_gen, transmitter).
// Optional parity support is selected by the UART_TX_PARITY_EN macro in transmitter.
package uart_tx_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BAUD_W   = 32;
  localparam int unsigned NBITS_W  = 4;

  localparam logic [NBITS_W-1:0] DATA_BITS_MIN = 4'd5;
  localparam logic [NBITS_W-1:0] DATA_BITS_MAX = 4'd8;

  localparam logic [1:0] STOP_SEL_ONE     = 2'd0;
  localparam logic [1:0] STOP_SEL_ONE_ALT = 2'd1;
  localparam logic [1:0] STOP_SEL_TWO     = 2'd2;
  localparam logic [1:0] STOP_SEL_TWO_ALT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic [NBITS_W-1:0] clamp_data_bits(input logic [NBITS_W-1:0] n);
    if (n < DATA_BITS_MIN) return DATA_BITS_MIN;
    if (n > DATA_BITS_MAX) return DATA_BITS_MAX;
    return n;
  endfunction

  function automatic logic stop_is_two(input logic [1:0] sel);
    case (sel)
      STOP_SEL_ONE, STOP_SEL_ONE_ALT: return 1'b0;
      STOP_SEL_TWO, STOP_SEL_TWO_ALT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divider-free baud tick: phase accumulator adds baud each clk and wraps at the clk frequency.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned clock_frequency_register = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [BAUD_W-1:0] baud,
  output logic              tick
);

  localparam logic [BAUD_W:0] FREQ = (BAUD_W+1)'(clock_frequency_register);

  logic [BAUD_W-1:0] acc_q, acc_d;
  logic              tick_q, tick_d;
  logic [BAUD_W:0]   sum;

  // clear restarts the phase from zero and already counts the current clk
  always_comb begin
    sum    = (clear ? (BAUD_W+1)'(0) : {1'b0, acc_q}) + {1'b0, baud};
    acc_d  = sum[BAUD_W-1:0];
    tick_d = 1'b0;
    if (baud != '0 && sum >= FREQ) begin
      acc_d  = BAUD_W'(sum - FREQ);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/transmitter.sv
// UART transmitter: latches a frame, then shifts start/data/parity/stop bits onto a registered TX.
// Macro UART_TX_PARITY_EN enables the optional even-parity bit (Transmitter_Status[5]).
module transmitter
  import uart_tx_pkg::*;
#(
  parameter int unsigned clock_frequency_register = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Baud_Rate_Holding_Register,
  input  logic [31:0] Transmitter_Holding_Register,
  input  logic [31:0] Transmitter_Status,
  output logic        TX
);

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_SUPPORTED = 1'b1;
`else
  localparam bit PARITY_SUPPORTED = 1'b0;
`endif

  tx_state_e          state_q, state_d;
  logic               tx_q, tx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NBITS_W-1:0] nbits_q, nbits_d;
  logic [NBITS_W-1:0] bit_idx_q, bit_idx_d;
  logic               par_en_q, par_en_d;
  logic               parity_q, parity_d;
  logic               stop_two_q, stop_two_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;

  logic               clear;
  logic               tick;
  logic               start_ok;
  logic [BAUD_W-1:0]  baud_sel;
  logic [NBITS_W-1:0] nbits_in;
  logic [DATA_W-1:0]  mask_in;
  logic               unused_inputs;

  assign unused_inputs = ^{Transmitter_Holding_Register[31:DATA_W], Transmitter_Status[31:8]};

  assign start_ok = Transmitter_Status[0] && (Baud_Rate_Holding_Register != '0);
  assign nbits_in = clamp_data_bits(Transmitter_Status[4:1]);
  assign mask_in  = DATA_W'((9'h1 << nbits_in) - 9'h1);
  // live baud while idle so the clearing cycle already adds the new rate
  assign baud_sel = (state_q == IDLE) ? Baud_Rate_Holding_Register : baud_q;

  uart_baud_gen #(
    .clock_frequency_register(clock_frequency_register)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .baud (baud_sel),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    data_d     = data_q;
    nbits_d    = nbits_q;
    bit_idx_d  = bit_idx_q;
    par_en_d   = par_en_q;
    parity_d   = parity_q;
    stop_two_d = stop_two_q;
    baud_d     = baud_q;
    clear      = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          data_d     = Transmitter_Holding_Register[DATA_W-1:0];
          nbits_d    = nbits_in;
          par_en_d   = PARITY_SUPPORTED && Transmitter_Status[5];
          parity_d   = ^(Transmitter_Holding_Register[DATA_W-1:0] & mask_in);
          stop_two_d = stop_is_two(Transmitter_Status[7:6]);
          baud_d     = Baud_Rate_Holding_Register;
          bit_idx_d  = '0;
          clear      = 1'b1;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = data_q[0];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == nbits_q - 4'd1) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d   = STOP;
              tx_d      = 1'b1;
              bit_idx_d = '0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            data_d    = {1'b0, data_q[DATA_W-1:1]};
            tx_d      = data_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_two_q && bit_idx_q == 4'd0) begin
            bit_idx_d = 4'd1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      data_q     <= '0;
      nbits_q    <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      stop_two_q <= 1'b0;
      baud_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      nbits_q    <= nbits_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      parity_q   <= parity_d;
      stop_two_q <= stop_two_d;
      baud_q     <= baud_d;
    end
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter; honours UART_TX_PARITY_EN the same way as the RTL build.
module tb_transmitter;

  localparam int unsigned F = 1000;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] baud = '0;
  logic [31:0] thr = '0;
  logic [31:0] tsr = '0;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;

  transmitter #(.clock_frequency_register(F)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .Baud_Rate_Holding_Register  (baud),
    .Transmitter_Holding_Register(thr),
    .Transmitter_Status          (tsr),
    .TX                          (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] baud;
    logic [31:0] data;
    logic [31:0] status;
    int          nbits;
    logic [15:0] bits;
  } vec_t;

  vec_t tbl [5];

  // Expected frame as a list of line levels, bit 0 sent first
  function automatic void model_frame(input logic [7:0] d, input logic [31:0] st,
                                      output logic [15:0] bits, output int n);
    int nd;
    int nstop;
    logic par;
    nd = int'(st[4:1]);
    if (nd < 5) nd = 5;
    if (nd > 8) nd = 8;
    nstop = (int'(st[7:6]) >= 2) ? 2 : 1;
    par = 1'b0;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin
      bits[n] = d[i];
      par ^= d[i];
      n++;
    end
    if (PAR && st[5]) begin
      bits[n] = par; n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    int first_bad;
    first_bad = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 && first_bad < 0) first_bad = c;
    end
    n_cmp++;
    if (first_bad >= 0) begin
      n_bad++;
      $display("FAIL %s: TX not 1 at idle cycle %0d, want constant 1", name, first_bad);
    end
  endtask

  // Bit j of a frame occupies cycles c with floor(c*baud/F) == j, c=0 at the first start-bit cycle
  task automatic check_frame(input string name, input logic [31:0] b, input logic [15:0] bits,
                             input int n, input int wait_max, input bit drop_en);
    int   bi;
    int   len;
    int   w;
    int   j;
    logic samp [0:255];
    bit   bad  [0:15];
    logic gotv [0:15];
    bi  = int'(b);
    len = (n * int'(F) + bi - 1) / bi;
    w   = 0;
    for (int k = 0; k < 16; k++) begin
      bad[k]  = 1'b0;
      gotv[k] = 1'b0;
    end
    @(negedge clk);
    while (tx !== 1'b0 && w < wait_max) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (tx !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start: got TX=%b after %0d cycles, want start bit 0", name, tx, wait_max);
      return;
    end
    if (drop_en) begin
      thr  = $urandom;
      tsr  = $urandom & ~32'h1;
      baud = $urandom_range(1, 900);
    end
    samp[0] = tx;
    for (int c = 1; c < len; c++) begin
      @(negedge clk);
      samp[c] = tx;
    end
    for (int c = 0; c < len; c++) begin
      j = (c * bi) / int'(F);
      if (samp[c] !== bits[j] && !bad[j]) begin
        bad[j]  = 1'b1;
        gotv[j] = samp[c];
      end
    end
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (bad[k]) begin
        n_bad++;
        $display("FAIL %s bit%0d: got TX=%b, want %b", name, k, gotv[k], bits[k]);
      end
    end
  endtask

  initial begin
    logic [15:0] mbits;
    int          mn;

    tbl[0] = '{32'd100, 32'h50, 32'h71, PAR ? 11 : 10, PAR ? 16'h04A0 : 16'h02A0};
    tbl[1] = '{32'd250, 32'h1F, 32'hC9, 8, 16'h00FE};
    tbl[2] = '{32'd333, 32'h07, 32'hB1, PAR ? 12 : 11, PAR ? 16'h0E0E : 16'h060E};
    tbl[3] = '{32'd77,  32'h81, 32'h1F, 10, 16'h0302};
    tbl[4] = '{32'd500, 32'h8B, 32'h6D, PAR ? 9 : 8, PAR ? 16'h0196 : 16'h0096};

    // Reset state, even with a valid start condition present
    baud = 32'd200; thr = 32'h00; tsr = 32'h11;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'h1);
    tsr = 32'h10;
    rst_n = 1'b1;
    check_idle("idle_after_reset", 20);

    // Table vectors: inputs scrambled and enable dropped right after the start bit
    for (int i = 0; i < 5; i++) begin
      baud = tbl[i].baud;
      thr  = tbl[i].data;
      tsr  = tbl[i].status;
      check_frame($sformatf("tbl%0d", i), tbl[i].baud, tbl[i].bits, tbl[i].nbits, 5, 1'b1);
      check_idle($sformatf("tbl%0d_after", i), 40);
    end

    // Baud zero never starts a frame
    baud = 32'd0; thr = 32'h00; tsr = 32'h11;
    check_idle("baud_zero", 300);

    // Continuous retransmission while enable stays high
    baud = 32'd250; thr = 32'h3C; tsr = 32'h11;
    model_frame(8'h3C, 32'h11, mbits, mn);
    check_frame("cont0", 32'd250, mbits, mn, 5, 1'b0);
    check_frame("cont1", 32'd250, mbits, mn, 3, 1'b0);
    check_frame("cont2", 32'd250, mbits, mn, 3, 1'b1);
    check_idle("cont_after", 30);

    // Asynchronous reset in the middle of the data bits
    baud = 32'd200; thr = 32'h00; tsr = 32'h11;
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (tx !== 1'b0 && w < 10) begin
        @(negedge clk);
        w++;
      end
      repeat (12) @(negedge clk);
      check("pre_reset_data", 32'(tx), 32'h0);
      #2 rst_n = 1'b0;
      #1 check("async_reset_tx", 32'(tx), 32'h1);
      thr = 32'h5A;
      repeat (4) @(negedge clk);
      check("reset_hold_tx", 32'(tx), 32'h1);
      rst_n = 1'b1;
    end
    model_frame(8'h5A, 32'h11, mbits, mn);
    check_frame("post_reset", 32'd200, mbits, mn, 4, 1'b1);
    check_idle("post_reset_after", 20);

    // Randomized frames against the model
    for (int r = 0; r < 20; r++) begin
      logic [31:0] rb;
      logic [31:0] rd;
      logic [31:0] rs;
      rb = $urandom_range(60, 900);
      rd = $urandom;
      rs = $urandom | 32'h1;
      baud = rb; thr = rd; tsr = rs;
      model_frame(rd[7:0], rs, mbits, mn);
      check_frame($sformatf("rand%0d", r), rb, mbits, mn, 5, 1'b1);
      check_idle($sformatf("rand%0d_after", r), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
